bp_io_host_responder: RTL and testbench

//  Synthesizable BedRock IO responder. It is the target end of the processor's io_cmd/io_resp

---
 rtl/bp_io_host_responder_if.sv | 52 +++++
 rtl/bp_io_host_responder.sv | 226 ++++++++++++++++++++++
 tb/tb_bp_io_host_responder.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/bp_io_host_responder_if.sv
// BedRock IO command/response bundle between the processor (master) and
// an IO target such as bp_io_host_responder (slave).
//
// Handshake rules:
//   - A command transfers on any clock edge where io_cmd_v_i && io_cmd_ready_o.
//     The master holds the command fields stable while io_cmd_v_i is high
//     and not yet accepted.
//   - A response is offered while io_resp_v_o is high. Its fields stay stable
//     until the consumer raises io_resp_yumi_i, which is legal only while
//     io_resp_v_o is high. The response is consumed on that edge.
//
// Signals:
//   io_cmd_type_i/addr_i/size_i/payload_i/data_i  command header and data
//   io_cmd_v_i / io_cmd_ready_o                    command valid / ready
//   io_resp_type_o/addr_o/size_o/payload_o/data_o  response header and data
//   io_resp_v_o / io_resp_yumi_i                   response valid / consume
interface bp_io_host_responder_if #(
  parameter int paddr_width_p = 40,
  parameter int data_width_p  = 64
);
  logic [3:0]               io_cmd_type_i;
  logic [paddr_width_p-1:0] io_cmd_addr_i;
  logic [2:0]               io_cmd_size_i;
  logic [15:0]              io_cmd_payload_i;
  logic [data_width_p-1:0]  io_cmd_data_i;
  logic                     io_cmd_v_i;
  logic                     io_cmd_ready_o;

  logic [3:0]               io_resp_type_o;
  logic [paddr_width_p-1:0] io_resp_addr_o;
  logic [2:0]               io_resp_size_o;
  logic [15:0]              io_resp_payload_o;
  logic [data_width_p-1:0]  io_resp_data_o;
  logic                     io_resp_v_o;
  logic                     io_resp_yumi_i;

  // Processor side: issues commands, consumes responses.
  modport master (
    output io_cmd_type_i, io_cmd_addr_i, io_cmd_size_i, io_cmd_payload_i,
           io_cmd_data_i, io_cmd_v_i, io_resp_yumi_i,
    input  io_cmd_ready_o, io_resp_type_o, io_resp_addr_o, io_resp_size_o,
           io_resp_payload_o, io_resp_data_o, io_resp_v_o
  );

  // Target side: accepts commands, returns responses.
  modport slave (
    input  io_cmd_type_i, io_cmd_addr_i, io_cmd_size_i, io_cmd_payload_i,
           io_cmd_data_i, io_cmd_v_i, io_resp_yumi_i,
    output io_cmd_ready_o, io_resp_type_o, io_resp_addr_o, io_resp_size_o,
           io_resp_payload_o, io_resp_data_o, io_resp_v_o
  );
endinterface

// File: rtl/bp_io_host_responder.sv
// Synthesizable BedRock IO responder. Target end of the io_cmd/io_resp channel;
// decodes uncached reads/writes to putchar, finish, scratch and char-count
// registers and returns exactly one response per accepted command.
//
// Ports:
//   clk_i, reset_i   clock and synchronous active-high reset
//   io               command/response bundle (slave side)
//   char_o, char_v_o putchar FIFO head byte and not-empty flag
//   char_yumi_i      pop FIFO head (ignored while empty)
//   finish_o         sticky per-core finish flags
//   err_o            sticky error: unmapped/misaligned address, bad type or size
//   state_o          FSM state for debug (0 READY, 1 STALL, 2 RESP)
//
// Address map on addr[19:0] (upper bits ignored, registers 8-byte aligned):
//   0x01000        putchar (write only)
//   0x02000 + 8*c  finish flag of core c (write sets, read returns flag)
//   0x03000 + 8*i  scratch register i (read/write)
//   0x04000        32-bit count of pushed characters (read only)
// An access in the wrong direction for a register counts as unmapped.
module bp_io_host_responder #(
  parameter int num_core_p      = 1,
  parameter int paddr_width_p   = 40,
  parameter int data_width_p    = 64,
  parameter int num_scratch_p   = 4,
  parameter int char_fifo_els_p = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  bp_io_host_responder_if.slave io,
  output logic [7:0]            char_o,
  output logic                  char_v_o,
  input  logic                  char_yumi_i,
  output logic [num_core_p-1:0] finish_o,
  output logic                  err_o,
  output logic [1:0]            state_o
);

  typedef enum logic [1:0] {
    S_READY = 2'd0,
    S_STALL = 2'd1,
    S_RESP  = 2'd2
  } state_e;

  localparam int aw = $clog2(char_fifo_els_p);
  localparam logic [aw:0] ptr_one = (aw+1)'(1);

  state_e state_r, state_n;

  // Latched command header, echoed in the response.
  logic [3:0]               type_r;
  logic [paddr_width_p-1:0] addr_r;
  logic [2:0]               size_r;
  logic [15:0]              payload_r;
  logic [data_width_p-1:0]  resp_data_r;
  // Putchar byte held while waiting for FIFO space.
  logic [7:0]               char_r;

  logic [data_width_p-1:0]  scratch_r [num_scratch_p];
  logic [num_core_p-1:0]    finish_r;
  logic                     err_r;
  logic [31:0]              char_cnt_r;

  logic [7:0]               fifo_mem [char_fifo_els_p];
  logic [aw:0]              wr_ptr_r, rd_ptr_r;
  logic                     fifo_full, fifo_empty;

  // Decode of the command currently on the bus.
  logic [19:0]              a;
  logic [8:0]               reg_idx;
  logic                     aligned;
  logic                     put_hit, fin_hit, scr_hit, cnt_hit;
  logic                     is_rd, is_wr, size_ok;
  logic                     wr_ok, rd_ok;
  logic [data_width_p-1:0]  mask;
  logic [data_width_p-1:0]  rd_val;

  logic                     cmd_ready, accept, push, pop;
  logic [7:0]               push_data;

  assign a       = io.io_cmd_addr_i[19:0];
  assign reg_idx = a[11:3];
  assign aligned = (a[2:0] == 3'd0);

  assign put_hit = (a == 20'h01000);
  assign cnt_hit = (a == 20'h04000);
  assign fin_hit = (a[19:12] == 8'h02) && aligned && (reg_idx < 9'(num_core_p));
  assign scr_hit = (a[19:12] == 8'h03) && aligned && (reg_idx < 9'(num_scratch_p));

  assign is_rd   = (io.io_cmd_type_i == 4'd2);
  assign is_wr   = (io.io_cmd_type_i == 4'd3);
  assign size_ok = ~io.io_cmd_size_i[2];

  assign wr_ok = is_wr && size_ok && (put_hit || fin_hit || scr_hit);
  assign rd_ok = is_rd && size_ok && (fin_hit || scr_hit || cnt_hit);

  // Byte mask for 2^size bytes, LSB-aligned.
  always_comb begin
    mask = '0;
    case (io.io_cmd_size_i[1:0])
      2'd0:    mask[7:0]  = '1;
      2'd1:    mask[15:0] = '1;
      2'd2:    mask[31:0] = '1;
      default: mask       = '1;
    endcase
  end

  // Unmasked register value for a read.
  always_comb begin
    rd_val = '0;
    if (fin_hit) begin
      for (int c = 0; c < num_core_p; c++) begin
        if (reg_idx == 9'(c)) rd_val[0] = finish_r[c];
      end
    end else if (scr_hit) begin
      for (int i = 0; i < num_scratch_p; i++) begin
        if (reg_idx == 9'(i)) rd_val = scratch_r[i];
      end
    end else if (cnt_hit) begin
      rd_val[31:0] = char_cnt_r;
    end
  end

  // Full when pointers match except for the wrap bit.
  assign fifo_full  = (wr_ptr_r[aw] != rd_ptr_r[aw]) &&
                      (wr_ptr_r[aw-1:0] == rd_ptr_r[aw-1:0]);
  assign fifo_empty = (wr_ptr_r == rd_ptr_r);
  assign pop        = char_yumi_i && !fifo_empty;

  // Next-state and control.
  always_comb begin
    state_n   = state_r;
    cmd_ready = 1'b0;
    push      = 1'b0;
    push_data = io.io_cmd_data_i[7:0];
    case (state_r)
      S_READY: begin
        cmd_ready = 1'b1;
        if (io.io_cmd_v_i) begin
          if (wr_ok && put_hit && fifo_full) begin
            state_n = S_STALL;
          end else begin
            state_n = S_RESP;
            push    = wr_ok && put_hit;
          end
        end
      end
      S_STALL: begin
        push_data = char_r;
        // A pop in this cycle frees the slot the push lands in.
        if (!fifo_full || pop) begin
          push    = 1'b1;
          state_n = S_RESP;
        end
      end
      S_RESP: begin
        if (io.io_resp_yumi_i) state_n = S_READY;
      end
      default: state_n = S_READY;
    endcase
  end

  assign accept = cmd_ready && io.io_cmd_v_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r     <= S_READY;
      type_r      <= '0;
      addr_r      <= '0;
      size_r      <= '0;
      payload_r   <= '0;
      resp_data_r <= '0;
      char_r      <= '0;
      finish_r    <= '0;
      err_r       <= 1'b0;
      char_cnt_r  <= '0;
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      for (int i = 0; i < num_scratch_p; i++) scratch_r[i] <= '0;
      for (int i = 0; i < char_fifo_els_p; i++) fifo_mem[i] <= '0;
    end else begin
      state_r <= state_n;

      if (accept) begin
        type_r      <= io.io_cmd_type_i;
        addr_r      <= io.io_cmd_addr_i;
        size_r      <= io.io_cmd_size_i;
        payload_r   <= io.io_cmd_payload_i;
        char_r      <= io.io_cmd_data_i[7:0];
        resp_data_r <= rd_ok ? (rd_val & mask) : '0;
        if (!(wr_ok || rd_ok)) err_r <= 1'b1;
        if (wr_ok && scr_hit) begin
          for (int i = 0; i < num_scratch_p; i++) begin
            if (reg_idx == 9'(i)) scratch_r[i] <= io.io_cmd_data_i & mask;
          end
        end
        if (wr_ok && fin_hit) begin
          for (int c = 0; c < num_core_p; c++) begin
            if (reg_idx == 9'(c)) finish_r[c] <= 1'b1;
          end
        end
      end

      if (push) begin
        fifo_mem[wr_ptr_r[aw-1:0]] <= push_data;
        wr_ptr_r   <= wr_ptr_r + ptr_one;
        char_cnt_r <= char_cnt_r + 32'd1;
      end
      if (pop) rd_ptr_r <= rd_ptr_r + ptr_one;
    end
  end

  assign io.io_cmd_ready_o    = cmd_ready;
  assign io.io_resp_v_o       = (state_r == S_RESP);
  assign io.io_resp_type_o    = type_r;
  assign io.io_resp_addr_o    = addr_r;
  assign io.io_resp_size_o    = size_r;
  assign io.io_resp_payload_o = payload_r;
  assign io.io_resp_data_o    = resp_data_r;

  assign char_o   = fifo_mem[rd_ptr_r[aw-1:0]];
  assign char_v_o = !fifo_empty;
  assign finish_o = finish_r;
  assign err_o    = err_r;
  assign state_o  = state_r;

endmodule

// File: tb/tb_bp_io_host_responder.sv
// Directed bench for bp_io_host_responder with two cores. Inputs change 1ns
// after the rising edge; outputs are sampled at the same point.
module tb_bp_io_host_responder;

  logic       clk = 1'b0;
  logic       reset_i;
  logic [7:0] char_o;
  logic       char_v_o;
  logic       char_yumi_i;
  logic [1:0] finish_o;
  logic       err_o;
  logic [1:0] state_o;

  int n_checks = 0;
  int n_err    = 0;

  bp_io_host_responder_if #(.paddr_width_p(40), .data_width_p(64)) io ();

  bp_io_host_responder #(
    .num_core_p(2), .paddr_width_p(40), .data_width_p(64),
    .num_scratch_p(4), .char_fifo_els_p(4)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .io(io),
    .char_o(char_o), .char_v_o(char_v_o), .char_yumi_i(char_yumi_i),
    .finish_o(finish_o), .err_o(err_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_cmd(input logic [3:0] t, input logic [39:0] a, input logic [2:0] s,
                         input logic [15:0] p, input logic [63:0] d);
    io.io_cmd_type_i    = t;
    io.io_cmd_addr_i    = a;
    io.io_cmd_size_i    = s;
    io.io_cmd_payload_i = p;
    io.io_cmd_data_i    = d;
  endtask

  // Present a command until accepted; returns #1 after the accepting edge.
  task automatic send_cmd(input logic [3:0] t, input logic [39:0] a, input logic [2:0] s,
                          input logic [15:0] p, input logic [63:0] d);
    bit done = 1'b0;
    set_cmd(t, a, s, p, d);
    io.io_cmd_v_i = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      done = io.io_cmd_ready_o;
      cycle();
    end
    io.io_cmd_v_i = 1'b0;
    chk("cmd_accept", 64'(done), 64'd1);
  endtask

  task automatic take_resp(input string tag, input logic [63:0] exp_d, input logic [15:0] exp_p);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (io.io_resp_v_o) seen = 1'b1;
      else cycle();
    end
    chk({tag, "_resp_v"}, 64'(seen), 64'd1);
    chk({tag, "_data"}, io.io_resp_data_o, exp_d);
    chk({tag, "_payload"}, 64'(io.io_resp_payload_o), 64'(exp_p));
    io.io_resp_yumi_i = 1'b1;
    cycle();
    io.io_resp_yumi_i = 1'b0;
  endtask

  task automatic pop_char();
    char_yumi_i = 1'b1;
    cycle();
    char_yumi_i = 1'b0;
  endtask

  initial begin
    reset_i           = 1'b1;
    char_yumi_i       = 1'b0;
    io.io_cmd_v_i     = 1'b0;
    io.io_resp_yumi_i = 1'b0;
    set_cmd(4'd0, 40'd0, 3'd0, 16'd0, 64'd0);
    repeat (3) cycle();
    reset_i = 1'b0;

    // Reset state
    chk("rst_ready", 64'(io.io_cmd_ready_o), 64'd1);
    chk("rst_resp_v", 64'(io.io_resp_v_o), 64'd0);
    chk("rst_char_v", 64'(char_v_o), 64'd0);
    chk("rst_finish", 64'(finish_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_resp_data", io.io_resp_data_o, 64'd0);
    chk("rst_resp_addr", 64'(io.io_resp_addr_o), 64'd0);
    chk("rst_state", 64'(state_o), 64'd0);

    // 1. Scratch write/read with size masking and one-cycle latency
    send_cmd(4'd3, 40'h03008, 3'd3, 16'h1234, 64'hDEAD_BEEF_0123_4567);
    chk("t1_wr_latency", 64'(io.io_resp_v_o), 64'd1);
    chk("t1_wr_type", 64'(io.io_resp_type_o), 64'd3);
    chk("t1_wr_addr", 64'(io.io_resp_addr_o), 64'h03008);
    take_resp("t1_wr", 64'd0, 16'h1234);
    send_cmd(4'd2, 40'h03008, 3'd2, 16'h0A5A, 64'd0);
    chk("t1_rd_latency", 64'(io.io_resp_v_o), 64'd1);
    chk("t1_rd_size", 64'(io.io_resp_size_o), 64'd2);
    take_resp("t1_rd_sz2", 64'h0123_4567, 16'h0A5A);
    send_cmd(4'd2, 40'h03008, 3'd3, 16'h0001, 64'd0);
    take_resp("t1_rd_sz3", 64'hDEAD_BEEF_0123_4567, 16'h0001);
    send_cmd(4'd2, 40'h03008, 3'd1, 16'h0002, 64'd0);
    take_resp("t1_rd_sz1", 64'h4567, 16'h0002);
    // Byte write zeroes the upper bytes of the register
    send_cmd(4'd3, 40'hF_0000_3010, 3'd0, 16'h0003, 64'hFFFF_FFFF_FFFF_FFAB);
    take_resp("t1_wr_b", 64'd0, 16'h0003);
    send_cmd(4'd2, 40'h03010, 3'd3, 16'h0004, 64'd0);
    take_resp("t1_rd_b", 64'h0000_0000_0000_00AB, 16'h0004);

    // 2. Putchar into a full FIFO stalls until a pop
    for (int k = 0; k < 4; k++) begin
      send_cmd(4'd3, 40'h01000, 3'd0, 16'(16'h100 + k), 64'(65 + k));
      take_resp("t2_put", 64'd0, 16'(16'h100 + k));
    end
    chk("t2_char_v", 64'(char_v_o), 64'd1);
    chk("t2_char_head", 64'(char_o), 64'h41);
    send_cmd(4'd3, 40'h01000, 3'd0, 16'h0105, 64'h45);
    chk("t2_stall_resp_v", 64'(io.io_resp_v_o), 64'd0);
    chk("t2_stall_ready", 64'(io.io_cmd_ready_o), 64'd0);
    chk("t2_stall_state", 64'(state_o), 64'd1);
    cycle();
    chk("t2_still_stall", 64'(state_o), 64'd1);
    pop_char();
    chk("t2_after_pop_resp_v", 64'(io.io_resp_v_o), 64'd1);
    chk("t2_after_pop_head", 64'(char_o), 64'h42);
    take_resp("t2_put5", 64'd0, 16'h0105);
    send_cmd(4'd2, 40'h04000, 3'd2, 16'h0200, 64'd0);
    take_resp("t2_count", 64'd5, 16'h0200);
    for (int k = 0; k < 4; k++) begin
      chk("t2_drain_v", 64'(char_v_o), 64'd1);
      chk("t2_drain_char", 64'(char_o), 64'(66 + k));
      pop_char();
    end
    chk("t2_empty", 64'(char_v_o), 64'd0);
    pop_char();
    chk("t2_pop_empty", 64'(char_v_o), 64'd0);
    send_cmd(4'd3, 40'h01000, 3'd0, 16'h0201, 64'h46);
    take_resp("t2_put_f", 64'd0, 16'h0201);
    chk("t2_f_v", 64'(char_v_o), 64'd1);
    chk("t2_f_char", 64'(char_o), 64'h46);
    pop_char();

    // 3. Finish flags
    chk("t3_err_clear", 64'(err_o), 64'd0);
    send_cmd(4'd3, 40'h02000, 3'd3, 16'h0300, 64'd1);
    take_resp("t3_fin_wr", 64'd0, 16'h0300);
    chk("t3_finish", 64'(finish_o), 64'h1);
    send_cmd(4'd2, 40'h02008, 3'd3, 16'h0301, 64'd0);
    take_resp("t3_rd_c1", 64'd0, 16'h0301);
    send_cmd(4'd2, 40'h02000, 3'd3, 16'h0302, 64'd0);
    take_resp("t3_rd_c0", 64'd1, 16'h0302);
    chk("t3_finish_sticky", 64'(finish_o), 64'h1);
    chk("t3_err_still_clear", 64'(err_o), 64'd0);

    // 4. Errors: unmapped read, cached type
    send_cmd(4'd2, 40'h05000, 3'd3, 16'h0400, 64'd0);
    take_resp("t4_unmapped", 64'd0, 16'h0400);
    chk("t4_err", 64'(err_o), 64'd1);
    send_cmd(4'd0, 40'h03008, 3'd3, 16'h0401, 64'hFFFF_0000_FFFF_0000);
    take_resp("t4_type0", 64'd0, 16'h0401);
    chk("t4_err_sticky", 64'(err_o), 64'd1);
    send_cmd(4'd2, 40'h03008, 3'd3, 16'h0402, 64'd0);
    take_resp("t4_scratch_kept", 64'hDEAD_BEEF_0123_4567, 16'h0402);
    chk("t4_finish_kept", 64'(finish_o), 64'h1);

    // 5. Response backpressure
    send_cmd(4'd2, 40'h03008, 3'd3, 16'h0500, 64'd0);
    set_cmd(4'd3, 40'h03008, 3'd3, 16'h0501, 64'h1111_2222_3333_4444);
    io.io_cmd_v_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cycle();
      chk("t5_hold_v", 64'(io.io_resp_v_o), 64'd1);
      chk("t5_hold_data", io.io_resp_data_o, 64'hDEAD_BEEF_0123_4567);
      chk("t5_hold_payload", 64'(io.io_resp_payload_o), 64'h0500);
      chk("t5_hold_ready", 64'(io.io_cmd_ready_o), 64'd0);
    end
    io.io_resp_yumi_i = 1'b1;
    cycle();
    io.io_resp_yumi_i = 1'b0;
    chk("t5_ready_after_yumi", 64'(io.io_cmd_ready_o), 64'd1);
    cycle();
    io.io_cmd_v_i = 1'b0;
    chk("t5_next_resp_v", 64'(io.io_resp_v_o), 64'd1);
    take_resp("t5_next", 64'd0, 16'h0501);
    send_cmd(4'd2, 40'h03008, 3'd3, 16'h0502, 64'd0);
    take_resp("t5_readback", 64'h1111_2222_3333_4444, 16'h0502);

    // 6. Reset during a stall with a full FIFO
    for (int k = 0; k < 4; k++) begin
      send_cmd(4'd3, 40'h01000, 3'd0, 16'(16'h600 + k), 64'(97 + k));
      take_resp("t6_put", 64'd0, 16'(16'h600 + k));
    end
    send_cmd(4'd3, 40'h01000, 3'd0, 16'h0604, 64'h65);
    chk("t6_stall_state", 64'(state_o), 64'd1);
    reset_i = 1'b1;
    cycle();
    chk("t6_ready", 64'(io.io_cmd_ready_o), 64'd1);
    chk("t6_char_v", 64'(char_v_o), 64'd0);
    chk("t6_resp_v", 64'(io.io_resp_v_o), 64'd0);
    chk("t6_finish", 64'(finish_o), 64'd0);
    chk("t6_err", 64'(err_o), 64'd0);
    reset_i = 1'b0;
    cycle();
    send_cmd(4'd2, 40'h03008, 3'd3, 16'h0605, 64'd0);
    take_resp("t6_scratch_cleared", 64'd0, 16'h0605);
    send_cmd(4'd2, 40'h04000, 3'd2, 16'h0606, 64'd0);
    take_resp("t6_count_cleared", 64'd0, 16'h0606);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
